// File: rtl/iseq_receiver_pkg.sv
// Shared opcode and FSM encodings for the Iseq receiver.
package iseq_receiver_pkg;

    localparam logic [3:0] END_ISEQ = 4'b1111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iseq_receiver_src_prio_arb.sv
// Fixed-priority arbiter: lowest request index wins; returns one-hot grant and index.
module src_prio_arb
    import iseq_receiver_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Scan downwards so the lowest asserted index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iseq_receiver.sv
// Iseq receiver: accepts instructions from prioritised sources and spreads them
// round-robin over the lane FIFOs; END starts execution, overlong Iseqs are flushed.
module iseq_receiver
    import iseq_receiver_pkg::*;
#(
    parameter int                 INSTR_W       = 32,
    parameter int                 NUM_SRC       = 2,
    parameter int                 NUM_LANES     = 2,
    parameter logic [NUM_SRC-1:0] SRC_STRIP_END = 2'b10,
    parameter int                 MAX_ISEQ_LEN  = 1024,
    parameter int                 LEN_W         = $clog2(MAX_ISEQ_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dispatcher_ready,
    input  logic                         rdback_fifo_empty,
    input  logic [NUM_SRC-1:0]           src_en,
    input  logic [NUM_SRC*INSTR_W-1:0]   src_instr,
    output logic [NUM_SRC-1:0]           src_ack,
    output logic [NUM_LANES-1:0]         lane_en,
    output logic [INSTR_W-1:0]           lane_data,
    input  logic [NUM_LANES-1:0]         lane_full,
    output logic                         lane_flush,
    output logic                         process_iseq,
    output logic [LEN_W-1:0]             iseq_len,
    output logic                         overflow_err,
    input  logic                         err_clr,
    output logic [1:0]                   dbg_state
);

    localparam int SRC_W = idx_w(NUM_SRC);
    localparam int PTR_W = idx_w(NUM_LANES);

    logic [1:0]           state;
    logic [SRC_W-1:0]     owner;
    logic [PTR_W-1:0]     ptr;
    logic [LEN_W-1:0]     count;
    logic                 rdback_empty_r;

    logic [NUM_SRC-1:0]   arb_grant;
    logic [SRC_W-1:0]     arb_idx;
    logic                 arb_any;

    logic                 stall, gate, accept, drain_acc;
    logic [SRC_W-1:0]     cur_src;
    logic [INSTR_W-1:0]   cur_instr;
    logic                 is_end, ovf_hit, do_write;
    logic [LEN_W-1:0]     count_inc;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_LANES-1:0] lane_sel;

    src_prio_arb #(.N(NUM_SRC), .IW(SRC_W)) u_arb (
        .req   (src_en),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign stall     = |lane_full;
    assign gate      = dispatcher_ready & ~process_iseq & rdback_empty_r;
    assign dbg_state = state;

    // Handshake: src_ack is combinational on the current cycle; a transfer
    // happens when src_en[i] & src_ack[i]. At most one source is ever acked.
    always_comb begin
        src_ack   = '0;
        accept    = 1'b0;
        drain_acc = 1'b0;
        cur_src   = owner;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    cur_src = arb_idx;
                    if (gate && !stall && arb_any) begin
                        src_ack = arb_grant;
                        accept  = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (!stall) begin
                        src_ack[owner] = 1'b1;
                        accept         = src_en[owner];
                    end
                end
                ST_DRAIN: begin
                    src_ack[owner] = 1'b1;
                    drain_acc      = src_en[owner];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_instr     = src_instr[int'(cur_src) * INSTR_W +: INSTR_W];
        is_end        = (cur_instr[INSTR_W-1 -: 4] == END_ISEQ);
        count_inc     = count + 1'b1;
        ovf_hit       = (count_inc == LEN_W'(MAX_ISEQ_LEN));
        do_write      = accept & (is_end ? ~SRC_STRIP_END[cur_src] : ~ovf_hit);
        ptr_next      = (ptr == PTR_W'(NUM_LANES - 1)) ? '0 : ptr + 1'b1;
        lane_sel      = '0;
        lane_sel[ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            owner          <= '0;
            ptr            <= '0;
            count          <= '0;
            rdback_empty_r <= 1'b1;
            lane_en        <= '0;
            lane_data      <= '0;
            lane_flush     <= 1'b0;
            process_iseq   <= 1'b0;
            iseq_len       <= '0;
            overflow_err   <= 1'b0;
        end else begin
            lane_en        <= '0;
            lane_flush     <= 1'b0;
            process_iseq   <= 1'b0;
            rdback_empty_r <= rdback_fifo_empty;

            if (do_write) begin
                lane_en   <= lane_sel;
                lane_data <= cur_instr;
            end

            // Next Iseq always starts at lane 0, whether the last one finished or was flushed.
            if (process_iseq || lane_flush) begin
                ptr <= '0;
            end else if (do_write) begin
                ptr <= ptr_next;
            end

            if (accept) begin
                owner <= cur_src;
                if (is_end) begin
                    process_iseq <= 1'b1;
                    iseq_len     <= count_inc;
                    count        <= '0;
                    state        <= ST_IDLE;
                end else if (ovf_hit) begin
                    lane_flush   <= 1'b1;
                    count        <= '0;
                    state        <= ST_DRAIN;
                end else begin
                    count        <= count_inc;
                    state        <= ST_RECV;
                end
            end else if (drain_acc && is_end) begin
                state <= ST_IDLE;
            end

            if (accept && !is_end && ovf_hit) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
        end
    end

endmodule
